// File: rtl/cvm300_pixel_packer_if.sv
// Signal bundle between the CVM300 capture packer, the sensor pins and the image FIFO write port.
// The slave side is the packer; the master side drives the sensor and FIFO-full inputs.
interface cvm300_pixel_packer_if;
  logic [9:0]  CVM300_D;
  logic        CVM300_Data_valid;
  logic        CVM300_Line_valid;
  logic        arm;
  logic        fifo_full;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        frame_done;
  logic [15:0] line_count;
  logic [19:0] word_count;
  logic        line_err;
  logic        overflow;

  modport master (
    output CVM300_D, CVM300_Data_valid, CVM300_Line_valid, arm, fifo_full,
    input  fifo_din, fifo_wr_en, frame_done, line_count, word_count, line_err, overflow
  );

  modport slave (
    input  CVM300_D, CVM300_Data_valid, CVM300_Line_valid, arm, fifo_full,
    output fifo_din, fifo_wr_en, frame_done, line_count, word_count, line_err, overflow
  );
endinterface

// File: rtl/cvm300_pixel_packer.sv
// Captures one CVM300 frame per arm edge, truncates pixels to 8 bits and packs four per FIFO word.
// Tracks pixel/line/word counts and raises sticky line-length and overflow flags.
module cvm300_pixel_packer #(
  parameter int PIX_PER_LINE = 648,
  parameter int LINES        = 488
) (
  input logic                  CVM300_CLK_OUT_i,
  input logic                  write_reset_i,
  cvm300_pixel_packer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_e;

  localparam logic [11:0] PixPerLine    = 12'(PIX_PER_LINE);
  localparam logic [15:0] LinesPerFrame = 16'(LINES);
  localparam logic [11:0] PixCntMax     = 12'hFFF;

  state_e      state_q, state_d;
  logic        armPrev_q;
  logic        lvalPrev_q;
  logic        seenLow_q, seenLow_d;
  logic [1:0]  pixIdx_q, pixIdx_d;
  logic [11:0] pixCnt_q, pixCnt_d;
  logic [23:0] packBuf_q, packBuf_d;
  logic [31:0] fifoDin_q, fifoDin_d;
  logic        fifoWrEn_q, fifoWrEn_d;
  logic        frameDone_q, frameDone_d;
  logic [15:0] lineCount_q, lineCount_d;
  logic [19:0] wordCount_q, wordCount_d;
  logic        lineErr_q, lineErr_d;
  logic        overflow_q, overflow_d;

  logic        lval;
  logic        dval;
  logic [7:0]  pixByte;
  logic        armRise;
  logic        lvalFall;
  logic        takePixel;
  logic        emitReq;
  logic [31:0] emitWord;
  logic        unusedDataLsbs;

  assign lval           = bus.CVM300_Line_valid;
  assign dval           = bus.CVM300_Data_valid;
  assign pixByte        = bus.CVM300_D[9:2];
  assign unusedDataLsbs = ^bus.CVM300_D[1:0];
  assign armRise        = bus.arm & ~armPrev_q;
  assign lvalFall       = lvalPrev_q & ~lval;

  always_comb begin
    state_d     = state_q;
    seenLow_d   = seenLow_q;
    pixIdx_d    = pixIdx_q;
    pixCnt_d    = pixCnt_q;
    packBuf_d   = packBuf_q;
    fifoDin_d   = fifoDin_q;
    fifoWrEn_d  = 1'b0;
    frameDone_d = frameDone_q;
    lineCount_d = lineCount_q;
    wordCount_d = wordCount_q;
    lineErr_d   = lineErr_q;
    overflow_d  = overflow_q;
    takePixel   = 1'b0;
    emitReq     = 1'b0;
    emitWord    = '0;

    case (state_q)
      IDLE, DONE: begin
        if (armRise) begin
          state_d     = ARMED;
          seenLow_d   = 1'b0;
          pixIdx_d    = '0;
          pixCnt_d    = '0;
          packBuf_d   = '0;
          frameDone_d = 1'b0;
          lineCount_d = '0;
          wordCount_d = '0;
          lineErr_d   = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      ARMED: begin
        // The cycle LVAL rises is already part of the first line, so its pixel is kept.
        if (!lval) begin
          seenLow_d = 1'b1;
        end else if (seenLow_q) begin
          state_d   = CAPTURE;
          takePixel = dval;
        end
      end
      CAPTURE: begin
        if (lvalFall) begin
          if (pixCnt_q != PixPerLine) begin
            lineErr_d = 1'b1;
          end
          if (pixIdx_q != 2'd0) begin
            emitReq  = 1'b1;
            emitWord = {8'h00, packBuf_q};
          end
          pixIdx_d    = '0;
          pixCnt_d    = '0;
          packBuf_d   = '0;
          lineCount_d = lineCount_q + 16'd1;
          if (lineCount_d == LinesPerFrame) begin
            state_d     = DONE;
            frameDone_d = 1'b1;
          end
        end else begin
          takePixel = lval & dval;
        end
      end
      default: state_d = IDLE;
    endcase

    if (takePixel) begin
      if (pixCnt_q != PixCntMax) begin
        pixCnt_d = pixCnt_q + 12'd1;
      end
      pixIdx_d = pixIdx_q + 2'd1;
      case (pixIdx_q)
        2'd0: packBuf_d[7:0]   = pixByte;
        2'd1: packBuf_d[15:8]  = pixByte;
        2'd2: packBuf_d[23:16] = pixByte;
        default: begin
          emitReq   = 1'b1;
          emitWord  = {pixByte, packBuf_q};
          packBuf_d = '0;
        end
      endcase
    end

    // Buffer is zeroed after every word, so a flush naturally carries zero upper lanes.
    if (emitReq) begin
      if (bus.fifo_full) begin
        overflow_d = 1'b1;
      end else begin
        fifoWrEn_d  = 1'b1;
        fifoDin_d   = emitWord;
        wordCount_d = wordCount_q + 20'd1;
      end
    end
  end

  always_ff @(posedge CVM300_CLK_OUT_i) begin
    if (write_reset_i) begin
      state_q     <= IDLE;
      armPrev_q   <= 1'b0;
      lvalPrev_q  <= 1'b0;
      seenLow_q   <= 1'b0;
      pixIdx_q    <= '0;
      pixCnt_q    <= '0;
      packBuf_q   <= '0;
      fifoDin_q   <= '0;
      fifoWrEn_q  <= 1'b0;
      frameDone_q <= 1'b0;
      lineCount_q <= '0;
      wordCount_q <= '0;
      lineErr_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      armPrev_q   <= bus.arm;
      lvalPrev_q  <= lval;
      seenLow_q   <= seenLow_d;
      pixIdx_q    <= pixIdx_d;
      pixCnt_q    <= pixCnt_d;
      packBuf_q   <= packBuf_d;
      fifoDin_q   <= fifoDin_d;
      fifoWrEn_q  <= fifoWrEn_d;
      frameDone_q <= frameDone_d;
      lineCount_q <= lineCount_d;
      wordCount_q <= wordCount_d;
      lineErr_q   <= lineErr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.fifo_din   = fifoDin_q;
  assign bus.fifo_wr_en = fifoWrEn_q;
  assign bus.frame_done = frameDone_q;
  assign bus.line_count = lineCount_q;
  assign bus.word_count = wordCount_q;
  assign bus.line_err   = lineErr_q;
  assign bus.overflow   = overflow_q;

endmodule
